// File: rtl/spir_master.sv
// SPI master (mode 0) that frames register read/write transactions for the FPGA SPI register slave.
// Each bit is one low half-period followed by one high half-period, each CLK_DIV system clocks long.

module spir_master #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CS_SETUP  = 2,
    parameter int unsigned CS_HOLD   = 2,
    parameter int unsigned CS_GAP    = 4,
    parameter int unsigned TURN_BITS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        spi_clk,
    output logic        spi_ncs,
    output logic        spi_dout,
    input  logic        spi_din
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HDR   = 3'd2;
    localparam logic [2:0] S_TURN  = 3'd3;
    localparam logic [2:0] S_WDATA = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;
    localparam logic [2:0] S_HOLD  = 3'd6;
    localparam logic [2:0] S_GAP   = 3'd7;

    localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_END  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_END   = 16'(CS_GAP - 1);

    // Bit indices (0-based, counted at each falling edge) of the last bit of each phase.
    localparam logic [8:0] HDR_END  = 9'd15;
    localparam logic [8:0] TURN_END = 9'(15 + TURN_BITS);
    localparam logic [8:0] WR_END   = 9'd47;
    localparam logic [8:0] RD_END   = 9'(47 + TURN_BITS);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [8:0]  r_bit;
    logic        r_wr;
    logic [46:0] r_tx;
    logic [31:0] r_rx;
    logic        r_spi_clk;
    logic        r_ncs;
    logic        r_dout;
    logic        r_rsp_valid;
    logic [31:0] r_rdata;

    logic w_accept;
    logic w_half_done;
    logic w_last_bit;

    assign req_ready   = reset_n && (r_state == S_IDLE);
    assign w_accept    = req_valid && req_ready;
    assign w_half_done = (r_cnt == DIV_END);
    assign w_last_bit  = (r_bit == (r_wr ? WR_END : RD_END));

    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign spi_clk   = r_spi_clk;
    assign spi_ncs   = r_ncs;
    assign spi_dout  = r_dout;

    // NOTE: every register here is updated with <= so all of them see the pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_wr        <= 1'b0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_spi_clk   <= 1'b0;
            r_ncs       <= 1'b1;
            r_dout      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_SETUP;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_wr    <= req_wr;
                        // Header MSB goes straight to spi_dout; the rest queues behind it.
                        r_tx    <= {3'b000, req_addr, (req_wr ? req_wdata : 32'h0)};
                        r_ncs   <= 1'b0;
                        r_dout  <= req_wr;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_END) begin
                        r_state <= S_HDR;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_HDR, S_TURN, S_WDATA, S_RDATA: begin
                    if (!w_half_done) begin
                        r_cnt <= r_cnt + 16'd1;
                    end else if (!r_spi_clk) begin
                        r_cnt     <= '0;
                        r_spi_clk <= 1'b1;
                        if (r_state == S_RDATA) begin
                            r_rx <= {r_rx[30:0], spi_din};
                        end
                    end else begin
                        r_cnt     <= '0;
                        r_spi_clk <= 1'b0;
                        r_bit     <= r_bit + 9'd1;
                        r_tx      <= {r_tx[45:0], 1'b0};
                        r_dout    <= r_tx[46];
                        if (w_last_bit) begin
                            r_state <= S_HOLD;
                            r_dout  <= 1'b0;
                        end else if (r_state == S_HDR && r_bit == HDR_END) begin
                            r_state <= r_wr ? S_WDATA : ((TURN_BITS == 0) ? S_RDATA : S_TURN);
                        end else if (r_state == S_TURN && r_bit == TURN_END) begin
                            r_state <= S_RDATA;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_END) begin
                        r_state     <= S_GAP;
                        r_cnt       <= '0;
                        r_ncs       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        if (!r_wr) begin
                            r_rdata <= r_rx;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_END) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spir_master.sv
// Self-checking bench for spir_master: two instances (default timing, and CLK_DIV=2/TURN_BITS=0),
// each watched by a cycle-level SPI slave/monitor that captures MOSI, supplies MISO and times the bus.

module tb_spir_master;

    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 4;

    logic        clk;
    logic        reset_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wr    [2];
    logic [11:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        busy      [2];
    logic        spi_clk   [2];
    logic        spi_ncs   [2];
    logic        spi_dout  [2];
    logic        spi_din   [2];

    // Monitor / slave-model state, one entry per instance.
    logic [31:0] slv_data      [2];
    logic [63:0] mosi          [2];
    int          rises         [2];
    int          low_cycles    [2];
    int          n_rsp         [2];
    int          n_setup_viol  [2];
    int          n_period_viol [2];
    int          n_overlap     [2];

    int n_assert = 0;
    int n_fail   = 0;

    spir_master #(
        .CLK_DIV(4), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP), .TURN_BITS(8)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .spi_clk(spi_clk[0]), .spi_ncs(spi_ncs[0]), .spi_dout(spi_dout[0]), .spi_din(spi_din[0])
    );

    spir_master #(
        .CLK_DIV(2), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP), .TURN_BITS(0)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .spi_clk(spi_clk[1]), .spi_ncs(spi_ncs[1]), .spi_dout(spi_dout[1]), .spi_din(spi_din[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
        $fatal(1, "watchdog expired");
    end

    // Slave + bus monitor, sampled on the falling system clock, away from the DUT update edge.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int DIV  = (g == 0) ? 4 : 2;
        localparam int TURN = (g == 0) ? 8 : 0;
        logic p_sclk, p_ncs, p_dout;
        int   since_rise = 0;
        int   since_chg  = 0;
        int   low_cnt    = 0;
        int   idx;

        always @(negedge clk) begin
            since_rise++;
            since_chg++;
            if (spi_dout[g] !== p_dout) since_chg = 0;
            if (p_ncs === 1'b1 && spi_ncs[g] === 1'b0) begin
                rises[g] = 0;
                mosi[g]  = '0;
                low_cnt  = 0;
            end
            if (spi_ncs[g] === 1'b0) begin
                low_cnt++;
                if (p_sclk === 1'b0 && spi_clk[g] === 1'b1) begin
                    if (rises[g] > 0 && since_rise != 2 * DIV) n_period_viol[g]++;
                    if (since_chg < DIV) n_setup_viol[g]++;
                    mosi[g]  = {mosi[g][62:0], spi_dout[g]};
                    rises[g] = rises[g] + 1;
                    since_rise = 0;
                end else if (p_sclk === 1'b1 && spi_clk[g] === 1'b0) begin
                    if (since_rise != DIV) n_period_viol[g]++;
                    // Slave presents read data MSB first after header + turnaround bits.
                    idx = rises[g] - (16 + TURN);
                    spi_din[g] = (idx >= 0 && idx < 32) ? slv_data[g][31 - idx] : 1'b0;
                end
            end else begin
                spi_din[g] = 1'b0;
            end
            if (p_ncs === 1'b0 && spi_ncs[g] === 1'b1) low_cycles[g] = low_cnt;
            if (rsp_valid[g] === 1'b1) n_rsp[g]++;
            if (rsp_valid[g] === 1'b1 && req_ready[g] === 1'b1) n_overlap[g]++;
            p_sclk = spi_clk[g];
            p_ncs  = spi_ncs[g];
            p_dout = spi_dout[g];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected spi_ncs low time from the frame rules: setup + bits * full period + hold.
    function automatic int exp_low(input int div, input int turn, input bit wr);
        return CS_SETUP + (48 + (wr ? 0 : turn)) * 2 * div + CS_HOLD;
    endfunction

    task automatic accept(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                          input bit scramble, output bit ok);
        int k = 0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_wr[d]    = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        while (req_ready[d] !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        ok = (req_ready[d] === 1'b1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        if (scramble) begin
            req_addr[d]  = 12'hFFF;
            req_wdata[d] = ~wd;
            req_wr[d]    = ~wr;
        end
    endtask

    task automatic wait_rsp(input int d, output logic [31:0] rd, output bit ok);
        int k = 0;
        while (rsp_valid[d] !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        ok = (rsp_valid[d] === 1'b1);
        rd = rsp_rdata[d];
        k = 0;
        while (busy[d] !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
    endtask

    initial begin
        bit          ok;
        logic [31:0] rd;
        logic [31:0] val;
        int          r0;
        int          k;
        int          ready_hits;
        int          gap;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_wr[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            slv_data[d]  = '0;
            n_rsp[d] = 0; n_setup_viol[d] = 0; n_period_viol[d] = 0; n_overlap[d] = 0;
            rises[d] = 0; low_cycles[d] = 0; mosi[d] = '0;
        end

        // Reset values
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ncs",       64'(spi_ncs[0]),   64'd1);
        check("rst_sclk",      64'(spi_clk[0]),   64'd0);
        check("rst_dout",      64'(spi_dout[0]),  64'd0);
        check("rst_ready",     64'(req_ready[0]), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        check("rst_rdata",     64'(rsp_rdata[0]), 64'd0);
        check("rst_busy",      64'(busy[0]),      64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 64'(req_ready[0]), 64'd1);

        // Write 0x800 <- DEADBEEF
        r0 = n_rsp[0];
        accept(0, 1'b1, 12'h800, 32'hDEADBEEF, 1'b0, ok);
        check("wr_accept", 64'(ok), 64'd1);
        wait_rsp(0, rd, ok);
        check("wr_rsp_seen",  64'(ok), 64'd1);
        check("wr_mosi",      mosi[0], {16'h0, 16'h8800, 32'hDEADBEEF});
        check("wr_rises",     64'(rises[0]), 64'd48);
        check("wr_ncs_low",   64'(low_cycles[0]), 64'(exp_low(4, 8, 1'b1)));
        check("wr_rsp_count", 64'(n_rsp[0] - r0), 64'd1);
        check("wr_rdata",     64'(rd), 64'd0);
        check("wr_rdata_hold", 64'(rsp_rdata[0]), 64'd0);

        // Read 0x040 -> 12345678
        slv_data[0] = 32'h12345678;
        r0 = n_rsp[0];
        accept(0, 1'b0, 12'h040, 32'hFFFF_FFFF, 1'b0, ok);
        check("rd_accept", 64'(ok), 64'd1);
        wait_rsp(0, rd, ok);
        check("rd_rsp_seen",   64'(ok), 64'd1);
        check("rd_header",     mosi[0] >> 40, 64'h0040);
        check("rd_rises",      64'(rises[0]), 64'd56);
        check("rd_ncs_low",    64'(low_cycles[0]), 64'(exp_low(4, 8, 1'b0)));
        check("rd_data_pulse", 64'(rd), 64'h12345678);
        check("rd_data_hold",  64'(rsp_rdata[0]), 64'h12345678);
        check("rd_rsp_count",  64'(n_rsp[0] - r0), 64'd1);

        // Back-to-back: req_valid held high, random write then read
        val = $urandom;
        slv_data[0] = $urandom;
        r0 = n_rsp[0];
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_wr[0]    = 1'b1;
        req_addr[0]  = 12'h155;
        req_wdata[0] = val;
        k = 0;
        while (req_ready[0] !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        req_wr[0]   = 1'b0;
        req_addr[0] = 12'h2AA;
        ready_hits = 0;
        k = 0;
        @(negedge clk);
        while (spi_ncs[0] === 1'b0 && k < 2000) begin
            if (req_ready[0] === 1'b1) ready_hits++;
            @(negedge clk);
            k++;
        end
        gap = 0;
        while (req_ready[0] !== 1'b1 && k < 2200) begin
            gap++;
            @(negedge clk);
            k++;
        end
        check("b2b_ready_low", 64'(ready_hits), 64'd0);
        check("b2b_first_mosi", mosi[0], {16'h0, 16'h8155, val});
        check("b2b_gap_ok", 64'((gap + 1) >= CS_GAP), 64'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_rsp(0, rd, ok);
        check("b2b_rsp_seen",  64'(ok), 64'd1);
        check("b2b_rd_header", mosi[0] >> 40, 64'h02AA);
        check("b2b_rd_data",   64'(rd), 64'(slv_data[0]));
        check("b2b_rsp_count", 64'(n_rsp[0] - r0), 64'd2);

        // Reset pulse in the middle of RDATA
        slv_data[0] = 32'h89ABCDEF;
        accept(0, 1'b0, 12'h0F0, 32'h0, 1'b0, ok);
        r0 = n_rsp[0];
        k = 0;
        while (rises[0] < 40 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("mid_rdata_reached", 64'(rises[0] >= 40), 64'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ncs",  64'(spi_ncs[0]), 64'd1);
        check("abort_sclk", 64'(spi_clk[0]), 64'd0);
        check("abort_busy", 64'(busy[0]),    64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", 64'(req_ready[0]), 64'd1);
        repeat (40) @(negedge clk);
        check("abort_no_rsp", 64'(n_rsp[0] - r0), 64'd0);
        check("abort_rdata",  64'(rsp_rdata[0]), 64'd0);

        // Request fields changed after accept must not reach the frame
        val = $urandom;
        accept(0, 1'b1, 12'h3C5, val, 1'b1, ok);
        check("chg_accept", 64'(ok), 64'd1);
        wait_rsp(0, rd, ok);
        check("chg_rsp_seen", 64'(ok), 64'd1);
        check("chg_mosi",     mosi[0], {16'h0, 16'h83C5, val});
        check("chg_ncs_low",  64'(low_cycles[0]), 64'(exp_low(4, 8, 1'b1)));

        // CLK_DIV=2, TURN_BITS=0 read
        slv_data[1] = 32'hA5A5_0F0F;
        accept(1, 1'b0, 12'h7E1, 32'h0, 1'b0, ok);
        check("fast_accept", 64'(ok), 64'd1);
        wait_rsp(1, rd, ok);
        check("fast_rsp_seen", 64'(ok), 64'd1);
        check("fast_header",   mosi[1] >> 32, 64'h07E1);
        check("fast_rises",    64'(rises[1]), 64'd48);
        check("fast_ncs_low",  64'(low_cycles[1]), 64'(exp_low(2, 0, 1'b0)));
        check("fast_rd_data",  64'(rd), 64'hA5A5_0F0F);

        // A second random read on the fast instance
        slv_data[1] = $urandom;
        accept(1, 1'b0, 12'(($urandom)), 32'h0, 1'b0, ok);
        wait_rsp(1, rd, ok);
        check("fast_rand_data", 64'(rd), 64'(slv_data[1]));

        for (int d = 0; d < 2; d++) begin
            check($sformatf("setup_viol_%0d", d),  64'(n_setup_viol[d]),  64'd0);
            check($sformatf("period_viol_%0d", d), 64'(n_period_viol[d]), 64'd0);
            check($sformatf("rsp_ready_%0d", d),   64'(n_overlap[d]),     64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
